// File: rtl/mlp_pkg.sv
// Shared types and helpers for the sequential dense-ReLU-dense MLP engine.
package mlp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    L1   = 2'd1,
    L2   = 2'd2,
    DONE = 2'd3
  } mlp_state_t;

  localparam logic [1:0] SEL_W1 = 2'd0;
  localparam logic [1:0] SEL_B1 = 2'd1;
  localparam logic [1:0] SEL_W2 = 2'd2;
  localparam logic [1:0] SEL_B2 = 2'd3;

  // Cycles from the accept cycle to the first cycle with out_valid high.
  function automatic int mlp_latency(input int in_dim, input int h_dim, input int out_dim);
    return 1 + h_dim * in_dim + out_dim * h_dim;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mlp_mac_unit.sv
// Shared signed multiply-accumulate: load (bias + product) or accumulate, wrapping at ACCW bits.
module mlp_mac_unit #(
  parameter int WW   = 8,
  parameter int ACCW = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en,
  input  logic                   i_load,
  input  logic signed [ACCW-1:0] i_a,
  input  logic signed [WW-1:0]   i_b,
  input  logic signed [ACCW-1:0] i_bias,
  output logic signed [ACCW-1:0] o_next
);

  logic signed [ACCW-1:0] r_acc;
  logic signed [ACCW-1:0] w_b_ext;
  logic signed [ACCW-1:0] w_prod;

  // Only the low ACCW bits of the product are kept, so an ACCW-wide multiply suffices.
  assign w_b_ext = ACCW'(i_b);
  assign w_prod  = i_a * w_b_ext;
  assign o_next  = (i_load ? i_bias : r_acc) + w_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_next;
    end
  end

endmodule

// File: rtl/mlp_seq_engine.sv
// Sequential 2-layer MLP (dense-ReLU-dense) with one shared MAC and runtime-loaded weights.
// Optional argmax on the logits is built when MLP_ARGMAX_EN is defined.
module mlp_seq_engine
  import mlp_pkg::*;
#(
  parameter int IN_DIM  = 64,
  parameter int H_DIM   = 8,
  parameter int OUT_DIM = 10,
  parameter int XW      = 8,
  parameter int WW      = 8,
  parameter int ACCW    = 32,
  parameter int AW      = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_DIM*XW-1:0]        x_flat,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_DIM*ACCW-1:0]     out_flat,
  output logic [$clog2(OUT_DIM)-1:0]  class_idx,
  input  logic                        wr_en,
  input  logic [1:0]                  wr_sel,
  input  logic [AW-1:0]               wr_addr,
  input  logic [ACCW-1:0]             wr_data,
  output logic [1:0]                  dbg_state
);

  localparam int CW   = $clog2(max3(IN_DIM, H_DIM, OUT_DIM));
  localparam int W1AW = $clog2(IN_DIM * H_DIM);
  localparam int W2AW = $clog2(H_DIM * OUT_DIM);
  localparam int HAW  = $clog2(H_DIM);
  localparam int OAW  = $clog2(OUT_DIM);
  localparam int CLW  = $clog2(OUT_DIM);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // in_ready is high only in IDLE, out_valid only in DONE, both decoded from state.
  mlp_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_i, r_j;
  logic [IN_DIM*XW-1:0] r_x;
  logic signed [ACCW-1:0] r_a1 [H_DIM];
  logic signed [ACCW-1:0] r_z2 [OUT_DIM];

  logic signed [WW-1:0]   r_w1 [IN_DIM*H_DIM];
  logic signed [ACCW-1:0] r_b1 [H_DIM];
  logic signed [WW-1:0]   r_w2 [H_DIM*OUT_DIM];
  logic signed [ACCW-1:0] r_b2 [OUT_DIM];

  logic                   w_last_i, w_last_j, w_mac_en;
  logic [W1AW-1:0]        w_w1_idx;
  logic [W2AW-1:0]        w_w2_idx;
  logic signed [XW-1:0]   w_x;
  logic signed [ACCW-1:0] w_mac_a, w_mac_bias, w_mac_next;
  logic signed [WW-1:0]   w_mac_b;

  assign dbg_state = r_state;
  assign w_last_i  = (r_state == L1) ? (r_i == CW'(IN_DIM - 1)) : (r_i == CW'(H_DIM - 1));
  assign w_last_j  = (r_state == L1) ? (r_j == CW'(H_DIM - 1))  : (r_j == CW'(OUT_DIM - 1));
  assign w_w1_idx  = W1AW'(r_i * H_DIM + r_j);
  assign w_w2_idx  = W2AW'(r_i * OUT_DIM + r_j);
  assign w_mac_en  = (r_state == L1) || (r_state == L2);

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = L1;
      end
      L1:   if (w_last_i && w_last_j) w_state_nxt = L2;
      L2:   if (w_last_i && w_last_j) w_state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // In L1 r_i walks inputs and r_j hidden neurons; in L2 r_i walks hidden and r_j outputs.
  always_comb begin
    w_mac_a    = '0;
    w_mac_b    = '0;
    w_mac_bias = '0;
    w_x        = r_x[r_i*XW +: XW];
    case (r_state)
      L1: begin
        w_mac_a    = ACCW'(w_x);
        w_mac_b    = r_w1[w_w1_idx];
        w_mac_bias = r_b1[HAW'(r_j)];
      end
      L2: begin
        w_mac_a    = r_a1[HAW'(r_i)];
        w_mac_b    = r_w2[w_w2_idx];
        w_mac_bias = r_b2[OAW'(r_j)];
      end
      default: ;
    endcase
  end

  mlp_mac_unit #(.WW(WW), .ACCW(ACCW)) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_mac_en),
    .i_load (r_i == '0),
    .i_a    (w_mac_a),
    .i_b    (w_mac_b),
    .i_bias (w_mac_bias),
    .o_next (w_mac_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_x     <= '0;
      for (int h = 0; h < H_DIM; h++) r_a1[h] <= '0;
      for (int k = 0; k < OUT_DIM; k++) r_z2[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          r_i <= '0;
          r_j <= '0;
          if (in_valid) r_x <= x_flat;
        end
        L1, L2: begin
          if (w_last_i) begin
            r_i <= '0;
            r_j <= w_last_j ? '0 : r_j + 1'b1;
            if (r_state == L1) r_a1[HAW'(r_j)] <= (w_mac_next > 0) ? w_mac_next : '0;
            else               r_z2[OAW'(r_j)] <= w_mac_next;
          end else begin
            r_i <= r_i + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < OUT_DIM; k++) begin : g_out
    assign out_flat[k*ACCW +: ACCW] = r_z2[k];
  end

  // Parameter storage is deliberately outside reset so weights survive an abort.
  always_ff @(posedge clk) begin
    if (wr_en && r_state == IDLE) begin
      case (wr_sel)
        SEL_W1: if (32'(wr_addr) < IN_DIM * H_DIM)  r_w1[W1AW'(wr_addr)] <= wr_data[WW-1:0];
        SEL_B1: if (32'(wr_addr) < H_DIM)           r_b1[HAW'(wr_addr)]  <= wr_data;
        SEL_W2: if (32'(wr_addr) < H_DIM * OUT_DIM) r_w2[W2AW'(wr_addr)] <= wr_data[WW-1:0];
        SEL_B2: if (32'(wr_addr) < OUT_DIM)         r_b2[OAW'(wr_addr)]  <= wr_data;
        default: ;
      endcase
    end
  end

`ifdef MLP_ARGMAX_EN
  logic signed [ACCW-1:0] r_max;
  logic [CLW-1:0]         r_idx;

  // Strict greater-than keeps the lowest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max <= '0;
      r_idx <= '0;
    end else if (r_state == L2 && w_last_i) begin
      if (r_j == '0 || w_mac_next > r_max) begin
        r_max <= w_mac_next;
        r_idx <= CLW'(r_j);
      end
    end
  end

  assign class_idx = r_idx;
`else
  assign class_idx = '0;
`endif

endmodule

// File: tb/tb_mlp_seq_engine.sv
// Directed bench for mlp_seq_engine with a logit scoreboard and a behavioural MLP model.
module tb_mlp_seq_engine;

  localparam int IN_DIM  = 64;
  localparam int H_DIM   = 8;
  localparam int OUT_DIM = 10;
  localparam int XW      = 8;
  localparam int WW      = 8;
  localparam int ACCW    = 32;
  localparam int AW      = 10;
  localparam int CLW     = $clog2(OUT_DIM);
  localparam int LAT     = 1 + H_DIM * IN_DIM + OUT_DIM * H_DIM;
  localparam int FW      = OUT_DIM * ACCW;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [IN_DIM*XW-1:0]    x_flat;
  logic                    out_valid;
  logic                    out_ready;
  logic [FW-1:0]           out_flat;
  logic [CLW-1:0]          class_idx;
  logic                    wr_en;
  logic [1:0]              wr_sel;
  logic [AW-1:0]           wr_addr;
  logic [ACCW-1:0]         wr_data;
  logic [1:0]              dbg_state;

  mlp_seq_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_flat    (x_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_flat  (out_flat),
    .class_idx (class_idx),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [ACCW-1:0] exp_q[$];
  logic [CLW-1:0]  cls_q[$];

  int m_x  [IN_DIM];
  int m_w1 [IN_DIM*H_DIM];
  int m_b1 [H_DIM];
  int m_w2 [H_DIM*OUT_DIM];
  int m_b2 [OUT_DIM];
  int m_z2 [OUT_DIM];
  int m_cls;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model();
    int a1 [H_DIM];
    int acc;
    for (int j = 0; j < H_DIM; j++) begin
      acc = m_b1[j];
      for (int i = 0; i < IN_DIM; i++) acc += m_x[i] * m_w1[i*H_DIM + j];
      a1[j] = (acc > 0) ? acc : 0;
    end
    for (int k = 0; k < OUT_DIM; k++) begin
      acc = m_b2[k];
      for (int j = 0; j < H_DIM; j++) acc += a1[j] * m_w2[j*OUT_DIM + k];
      m_z2[k] = acc;
    end
    m_cls = 0;
    for (int k = 1; k < OUT_DIM; k++) if (m_z2[k] > m_z2[m_cls]) m_cls = k;
  endfunction

  function automatic int sx(input logic [ACCW-1:0] d);
    logic signed [WW-1:0] w;
    w = d[WW-1:0];
    return int'(w);
  endfunction

  task automatic wr(input logic [1:0] sel, input int addr, input logic [ACCW-1:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr[AW-1:0]; wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
    case (sel)
      2'd0: if (addr < IN_DIM*H_DIM)  m_w1[addr] = sx(data);
      2'd1: if (addr < H_DIM)         m_b1[addr] = int'(data);
      2'd2: if (addr < H_DIM*OUT_DIM) m_w2[addr] = sx(data);
      default: if (addr < OUT_DIM)    m_b2[addr] = int'(data);
    endcase
  endtask

  task automatic fill(input logic [1:0] sel, input int count, input int value);
    for (int a = 0; a < count; a++) wr(sel, a, ACCW'(value));
  endtask

  // hold: cycles of back-pressure on out_ready; mid_wr: cycle of an ignored W1 write;
  // abort_at: cycle at which rst_n is pulsed; acc_wr: W2[0]=5 written on the accept edge.
  task automatic run_vector(input int hold, input int mid_wr, input int abort_at, input bit acc_wr);
    logic [FW-1:0]  exp_flat;
    logic [CLW-1:0] exp_c;
    int n;
    if (acc_wr) m_w2[0] = 5;
    model();
    for (int k = 0; k < OUT_DIM; k++) exp_q.push_back(ACCW'(m_z2[k]));
    cls_q.push_back(CLW'(m_cls));
    for (int i = 0; i < IN_DIM; i++) x_flat[i*XW +: XW] = XW'(m_x[i]);
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    if (acc_wr) begin
      wr_en = 1'b1; wr_sel = 2'd2; wr_addr = '0; wr_data = 32'd5;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wr_en    = 1'b0;
    n = 1;
    while (!out_valid && n < LAT + 50) begin
      if (n == mid_wr) begin
        wr_en = 1'b1; wr_sel = 2'd0; wr_addr = '0; wr_data = 32'd7;
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
      n++;
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", FW'(out_valid), FW'(0));
        chk("abort_in_ready", FW'(in_ready), FW'(1));
        chk("abort_out_flat", out_flat, '0);
        chk("abort_state", FW'(dbg_state), FW'(0));
        exp_q.delete();
        cls_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
    end
    chk("latency", FW'(n), FW'(LAT));
    if (!out_valid) begin
      exp_q.delete();
      cls_q.delete();
      return;
    end
    exp_flat = '0;
    for (int k = 0; k < OUT_DIM; k++) begin
      exp_flat[k*ACCW +: ACCW] = exp_q.pop_front();
      chk($sformatf("z2[%0d]", k), FW'(out_flat[k*ACCW +: ACCW]), FW'(exp_flat[k*ACCW +: ACCW]));
    end
    exp_c = cls_q.pop_front();
`ifndef MLP_ARGMAX_EN
    exp_c = '0;
`endif
    chk("class_idx", FW'(class_idx), FW'(exp_c));
    for (int h = 0; h < hold; h++) begin
      chk("hold_out_valid", FW'(out_valid), FW'(1));
      chk("hold_in_ready", FW'(in_ready), FW'(0));
      chk("hold_out_flat", out_flat, exp_flat);
      chk("hold_class_idx", FW'(class_idx), FW'(exp_c));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_out_valid", FW'(out_valid), FW'(0));
    chk("post_in_ready", FW'(in_ready), FW'(1));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x_flat = '0;
    wr_en = 1'b0; wr_sel = '0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", FW'(in_ready), FW'(1));
    chk("rst_out_valid", FW'(out_valid), FW'(0));
    chk("rst_out_flat", out_flat, '0);
    chk("rst_class_idx", FW'(class_idx), FW'(0));
    chk("rst_state", FW'(dbg_state), FW'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All-ones network: every logit 512.
    for (int i = 0; i < IN_DIM; i++) m_x[i] = 1;
    fill(2'd0, IN_DIM*H_DIM, 1);
    fill(2'd1, H_DIM, 0);
    fill(2'd2, H_DIM*OUT_DIM, 1);
    fill(2'd3, OUT_DIM, 0);
    run_vector(0, -1, -1, 1'b0);

    // W1 write while busy is dropped; the same write in IDLE lands.
    run_vector(0, 10, -1, 1'b0);
    wr(2'd0, 0, 32'd7);
    run_vector(0, -1, -1, 1'b0);

    // Abort mid-L1, then rerun with the retained weights.
    run_vector(0, -1, 200, 1'b0);
    chk("abort_rerun_q_empty", FW'(exp_q.size()), FW'(0));
    run_vector(0, -1, -1, 1'b0);

    // ReLU clamps every hidden unit; negative logits; back-pressure.
    fill(2'd0, IN_DIM*H_DIM, 1);
    fill(2'd1, H_DIM, -100);
    fill(2'd2, H_DIM*OUT_DIM, 3);
    for (int k = 0; k < OUT_DIM; k++) wr(2'd3, k, ACCW'(k - 5));
    run_vector(20, -1, -1, 1'b0);

    // Tie between k=3 and k=7 at the maximum.
    fill(2'd1, H_DIM, 0);
    fill(2'd2, H_DIM*OUT_DIM, 0);
    for (int k = 0; k < OUT_DIM; k++) wr(2'd3, k, ACCW'((k == 3 || k == 7) ? 100 : k));
    run_vector(0, -1, -1, 1'b0);

    // Most negative input and weight over all terms; out-of-range writes ignored.
    for (int i = 0; i < IN_DIM; i++) m_x[i] = -128;
    fill(2'd0, IN_DIM*H_DIM, -128);
    for (int a = 0; a < H_DIM*OUT_DIM; a++) wr(2'd2, a, ACCW'((a < OUT_DIM) ? 1 : 0));
    fill(2'd3, OUT_DIM, 0);
    wr(2'd1, H_DIM, 32'h0100_0000);
    wr(2'd3, OUT_DIM, 32'h0100_0000);
    run_vector(0, -1, -1, 1'b0);

    // Random network, with a W2 write landing on the accept edge.
    for (int i = 0; i < IN_DIM; i++) m_x[i] = int'($urandom_range(0, 255)) - 128;
    for (int a = 0; a < IN_DIM*H_DIM; a++) wr(2'd0, a, ACCW'($urandom_range(0, 255)));
    for (int j = 0; j < H_DIM; j++) wr(2'd1, j, ACCW'(int'($urandom_range(0, 4000)) - 2000));
    for (int a = 0; a < H_DIM*OUT_DIM; a++) wr(2'd2, a, ACCW'($urandom_range(0, 255)));
    for (int k = 0; k < OUT_DIM; k++) wr(2'd3, k, $urandom);
    run_vector(0, -1, -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
